// File: rtl/lsu_mem_align.sv
// Load/store unit between the core datapath and the data-memory bus: byte-lane
// alignment, load extension, and splitting of word-crossing accesses into two beats.
module lsu_mem_align #(
    parameter int unsigned XLEN             = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata
);
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);
    localparam int unsigned OFW1  = OFFW + 1;
    localparam int unsigned SHW   = OFFW + 4;
    localparam int unsigned CW    = OFFW + 2;
    localparam int unsigned IDXW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES = '1;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t            state;
    logic              we_q;
    logic              split_q;
    logic [2:0]        f3_q;
    logic [OFFW-1:0]   off_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   base_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   hi_q;

    logic [OFFW-1:0]   off_in;
    logic [3:0]        n_in;
    logic              split_in;
    logic              illegal_in;
    logic              err_in;
    logic [15:0]       mask_in;
    logic [BYTES-1:0]  be0_in;
    logic [XLEN-1:0]   wdata0_in;
    logic [XLEN-1:0]   base_in;

    logic [15:0]       mask_q;
    logic [OFFW:0]     rem_q;
    logic [BYTES-1:0]  be1_q;
    logic [XLEN-1:0]   wdata1_q;

    logic [XLEN-1:0]   lo_src;
    logic [XLEN-1:0]   hi_src;
    logic [XLEN-1:0]   aligned;
    logic [SHW-1:0]    nbits;
    logic [IDXW-1:0]   sidx;
    logic [XLEN-1:0]   keep;
    logic              sbit;
    logic [XLEN-1:0]   load_data;

    // Decode of the incoming request: size, lane offset, split and error detection.
    always_comb begin
        off_in     = req_addr[OFFW-1:0];
        n_in       = 4'(1) << req_funct3[1:0];
        split_in   = (CW'(off_in) + CW'(n_in)) > CW'(BYTES);
        illegal_in = (req_funct3 == 3'b111) || (req_we && req_funct3[2]) ||
                     ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
        err_in     = illegal_in || (split_in && !ALLOW_MISALIGNED);
        mask_in    = (16'(1) << n_in) - 16'd1;
        be0_in     = BYTES'(mask_in << off_in);
        wdata0_in  = req_wdata << {off_in, 3'b000};
        base_in    = req_addr & ~XLEN'(BYTES - 1);
    end

    // Second-beat lanes: the bytes that spilled past the first word.
    always_comb begin
        mask_q   = (16'(1) << (4'(1) << f3_q[1:0])) - 16'd1;
        rem_q    = OFW1'(BYTES) - {1'b0, off_q};
        be1_q    = BYTES'(mask_q >> rem_q);
        wdata1_q = wdata_q >> {rem_q, 3'b000};
    end

    // Load assembly uses the live bus data in the beat that completes the access.
    always_comb begin
        lo_src    = (state == WAIT0) ? mem_rdata : lo_q;
        hi_src    = (state == WAIT1) ? mem_rdata : hi_q;
        aligned   = XLEN'({hi_src, lo_src} >> {off_q, 3'b000});
        nbits     = SHW'(4'(1) << f3_q[1:0]) << 3;
        sidx      = IDXW'(nbits - SHW'(1));
        keep      = ~(ONES << nbits);
        sbit      = aligned[sidx] & ~f3_q[2];
        load_data = (aligned & keep) | ({XLEN{sbit}} & ~keep);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            split_q   <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            base_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= off_in;
                        split_q   <= split_in;
                        wdata_q   <= req_wdata;
                        base_q    <= base_in;
                        req_ready <= 1'b0;
                        if (err_in) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= REQ0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= base_in;
                            mem_be    <= be0_in;
                            mem_wdata <= wdata0_in;
                        end
                    end
                end
                REQ0: begin
                    if (mem_gnt) begin
                        if (we_q && split_q) begin
                            state     <= REQ1;
                            mem_addr  <= base_q + XLEN'(BYTES);
                            mem_be    <= be1_q;
                            mem_wdata <= wdata1_q;
                        end else begin
                            state     <= we_q ? RESP : WAIT0;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_be    <= '0;
                            mem_wdata <= '0;
                            if (we_q) begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                rsp_rdata <= '0;
                            end
                        end
                    end
                end
                WAIT0: begin
                    if (mem_rvalid) begin
                        lo_q <= mem_rdata;
                        if (split_q) begin
                            state     <= REQ1;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= base_q + XLEN'(BYTES);
                            mem_be    <= be1_q;
                            mem_wdata <= wdata1_q;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= load_data;
                        end
                    end
                end
                REQ1: begin
                    if (mem_gnt) begin
                        state     <= we_q ? RESP : WAIT1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (we_q) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        hi_q      <= mem_rdata;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_align.sv
// Bench for lsu_mem_align: byte-level memory model, directed cases and randomized
// accesses with random grant/read-data stalls; a strict instance covers misalignment errors.
module tb_lsu_mem_align;
    logic        clk, rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        s_req_ready, s_rsp_valid, s_rsp_err, s_mem_req, s_mem_we;
    logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_be;

    int          n_cmp, n_mis;
    logic [31:0] mem [bit [31:0]];
    logic [31:0] last_exp;

    logic [31:0] o_rdata, s_rdata;
    logic        o_err, s_err, s_busy;
    int          o_lat, s_lat, o_beats;
    logic [31:0] o_addr [2];
    logic [31:0] o_wdata [2];
    logic [3:0]  o_be [2];
    logic        o_we [2];

    lsu_mem_align #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_align #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_strict (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_rsp_valid), .rsp_err(s_rsp_err), .rsp_rdata(s_rsp_rdata),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_be(s_mem_be),
        .mem_wdata(s_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    task automatic rst_vals(input string tag);
        chk({tag, "_ready"}, req_ready, 1);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err}, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
        chk({tag, "_bus"}, {mem_req, mem_we, mem_be}, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    // One access: reference expectations from byte-level rules, then act as the bus slave.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit rnd);
        int          n, off, enb, elat, extra, cyc, beat, gw, rw;
        bit          split, illegal, e_err0, e_err1, started, rvp, done0, done1;
        logic [31:0] wa0, a, w, v, erd, raddr;
        logic [31:0] eaddr [2];
        logic [31:0] ewd [2];
        logic [3:0]  ebe [2];

        n       = 1 << f3[1:0];
        off     = int'(addr[1:0]);
        split   = (off + n) > 4;
        illegal = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110) || (we && f3[2]);
        e_err0  = illegal;
        e_err1  = illegal || split;
        wa0     = addr & ~32'd3;
        ebe[0]  = '0;
        ebe[1]  = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if ((a & ~32'd3) == wa0) ebe[0][a[1:0]] = 1'b1;
            else ebe[1][a[1:0]] = 1'b1;
        end
        eaddr[0] = wa0;
        eaddr[1] = wa0 + 32'd4;
        ewd[0]   = wdata << (8 * off);
        ewd[1]   = (off == 0) ? 32'd0 : wdata >> (8 * (4 - off));
        enb      = e_err0 ? 0 : (split ? 2 : 1);
        erd      = '0;
        if (!we && !e_err0) begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                w = rd_word(a & ~32'd3);
                v = v | (((w >> (8 * int'(a[1:0]))) & 32'hFF) << (8 * i));
            end
            if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            erd = v;
        end
        elat = e_err0 ? 1 : (we ? (split ? 3 : 2) : (split ? 5 : 3));

        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        chk("idle_rsp", rsp_valid, 0);
        chk("rdata_hold", rsp_rdata, last_exp);
        chk("strict_ready", s_req_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        cyc = 0; extra = 0; beat = 0; started = 0; gw = 0; rw = 0; rvp = 0;
        done0 = 0; done1 = 0; s_busy = 0; raddr = '0;
        while (!(done0 && done1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            s_busy = s_busy | s_mem_req | s_mem_we | (|s_mem_be) | (|s_mem_wdata) | (|s_mem_addr);
            if (!done1 && s_rsp_valid) begin
                done1 = 1; s_lat = cyc; s_err = s_rsp_err; s_rdata = s_rsp_rdata;
            end
            if (!done0 && rsp_valid) begin
                done0 = 1; o_lat = cyc; o_err = rsp_err; o_rdata = rsp_rdata;
                chk("rsp_ready_low", req_ready, 0);
            end else if (!done0) begin
                if (rvp) begin
                    if (rw > 0) begin rw--; extra++; end
                    else begin mem_rvalid = 1'b1; mem_rdata = rd_word(raddr); rvp = 0; end
                    if (rnd && $urandom_range(0, 1) == 1) mem_gnt = 1'b1;
                end
                if (mem_req) begin
                    if (!started) begin started = 1; gw = rnd ? int'($urandom_range(0, 2)) : 0; end
                    if (rnd && $urandom_range(0, 1) == 1) mem_rvalid = 1'b1;
                    if (gw > 0) begin
                        gw--; extra++;
                    end else begin
                        mem_gnt = 1'b1; started = 0;
                        if (beat < 2) begin
                            o_addr[beat] = mem_addr; o_be[beat] = mem_be;
                            o_we[beat] = mem_we; o_wdata[beat] = mem_wdata;
                        end
                        if (!we) begin
                            rvp = 1; rw = rnd ? int'($urandom_range(0, 2)) : 0;
                            raddr = eaddr[(beat < 2) ? beat : 1];
                        end
                        beat++;
                    end
                end else begin
                    chk("quiet_be_we", {mem_we, mem_be}, 0);
                    chk("quiet_wdata", mem_wdata, 0);
                end
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        o_beats = beat;
        chk("rsp_seen", done0, 1);
        chk("strict_rsp_seen", done1, 1);
        chk("err", o_err, e_err0);
        chk("rdata", o_rdata, (e_err0 || we) ? 32'd0 : erd);
        chk("latency", o_lat, elat + extra);
        chk("beats", beat, enb);
        for (int b = 0; b < enb && b < beat && b < 2; b++) begin
            chk("beat_addr", o_addr[b], eaddr[b]);
            chk("beat_be", o_be[b], ebe[b]);
            chk("beat_we", o_we[b], we);
            if (we) chk("beat_wdata", o_wdata[b], ewd[b]);
        end
        chk("strict_err", s_err, e_err1);
        chk("strict_rdata", s_rdata, (e_err1 || we) ? 32'd0 : erd);
        if (e_err1) begin
            chk("strict_lat", s_lat, 1);
            chk("strict_no_bus", s_busy, 0);
        end else begin
            chk("strict_lat", s_lat, o_lat);
        end
        if (we && !e_err0) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                w = rd_word(a & ~32'd3);
                w[8 * int'(a[1:0]) +: 8] = wdata[8 * i +: 8];
                mem[a & ~32'd3] = w;
            end
        end
        last_exp = (e_err0 || we) ? 32'd0 : erd;
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; last_exp = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst_vals("reset");
        rst_n = 1'b1;

        // Aligned word load.
        mem[32'h100] = 32'hDEADBEEF;
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
        chk("lw_rdata", o_rdata, 32'hDEADBEEF);
        chk("lw_lat", o_lat, 3);
        chk("lw_be", o_be[0], 4'b1111);

        // Signed and unsigned byte loads from the top lane.
        mem[32'h100] = 32'h80112233;
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 1'b0);
        chk("lb_rdata", o_rdata, 32'hFFFFFF80);
        chk("lb_be", o_be[0], 4'b1000);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 1'b0);
        chk("lbu_rdata", o_rdata, 32'h00000080);

        // Word-crossing load; the strict instance must reject it.
        mem[32'h0FC] = 32'h44332211;
        mem[32'h100] = 32'h88776655;
        do_access(1'b0, 3'b010, 32'h0FE, 32'h0, 1'b0);
        chk("split_rdata", o_rdata, 32'h66554433);
        chk("split_lat", o_lat, 5);
        chk("split_b0", {o_addr[0][11:0], o_be[0]}, {12'h0FC, 4'b1100});
        chk("split_b1", {o_addr[1][11:0], o_be[1]}, {12'h100, 4'b0011});
        chk("strict_mis_err", s_err, 1);

        // Reset while waiting for read data, then a late rvalid.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_pre_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rst_in_wait", mem_req, 0);
        #2 rst_n = 1'b0;
        #1 rst_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        repeat (4) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            chk("rst_no_rsp", rsp_valid, 0);
            chk("rst_idle_ready", req_ready, 1);
        end
        last_exp = '0;

        // Halfword store in the upper lanes.
        do_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1'b0);
        chk("sh_be", o_be[0], 4'b1100);
        chk("sh_wdata", o_wdata[0], 32'hABCD0000);
        chk("sh_we", o_we[0], 1);
        chk("sh_lat", o_lat, 2);

        // Doubleword funct3 is illegal at XLEN=32.
        do_access(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
        chk("ld_err", o_err, 1);
        chk("ld_lat", o_lat, 1);

        // Split store wrapping the address space.
        do_access(1'b1, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 1'b0);
        chk("wrap_b0", o_addr[0], 32'hFFFFFFFC);
        chk("wrap_b0_wd", o_wdata[0], 32'hCCDD0000);
        chk("wrap_b1", o_addr[1], 32'h00000000);
        chk("wrap_b1_wd", o_wdata[1], 32'h0000AABB);
        chk("wrap_lat", o_lat, 3);

        // Randomized accesses with bus stalls.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] ra;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else ra = 32'h200 + 32'($urandom_range(0, 63));
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
